// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches ahead of decode, buffers
// returned words with their PC+1, and flushes everything on an ID-stage redirect.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OS   = 2,
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     im_req,
    output logic [9:0]               im_addr,
    input  logic                     im_valid,
    input  logic [31:0]              im_rdata,
    input  logic                     redirect,
    input  logic [29:0]              redirect_pc,
    input  logic                     id_ready,
    output logic                     if_valid,
    output logic [31:0]              if_instr,
    output logic [29:0]              if_pcaddone,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;

    logic [29:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [29:0]   pcp1_mem_q  [DEPTH];
    logic [29:0]   tag_q       [MAX_OS];

    logic          issue;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OS - 1)) ? '0 : p + TW'(1);
    endfunction

    // Queued plus in-flight entries never exceed DEPTH, so every response has a slot.
    assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue = rst & ~redirect & (inflight_q < CW'(MAX_OS))
                 & (credit_used < (CW + 1)'(DEPTH));
    assign drop  = im_valid & (drop_cnt_q != '0);
    assign push  = im_valid & ~drop & ~redirect;
    assign pop   = if_valid & id_ready & ~redirect;

    assign im_req      = issue;
    assign im_addr     = fetch_pc_q[9:0];
    assign if_valid    = (count_q != '0);
    assign if_instr    = if_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign if_pcaddone = if_valid ? pcp1_mem_q[rd_ptr_q] : 30'h0;
    assign q_count     = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        inflight_d = inflight_q + CW'(issue) - CW'(im_valid);
        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            drop_cnt_d = inflight_q - CW'(im_valid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 30'd1;
                tag_wr_d   = tag_inc(tag_wr_q);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                tag_rd_d = tag_inc(tag_rd_q);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pcp1_mem_q[i]  <= '0;
            end
            for (int i = 0; i < MAX_OS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                tag_q[tag_wr_q] <= fetch_pc_q;
            end
            if (push) begin
                instr_mem_q[wr_ptr_q] <= im_rdata;
                pcp1_mem_q[wr_ptr_q]  <= tag_q[tag_rd_q] + 30'd1;
            end
        end
    end

endmodule
